// File: rtl/gam_winner_search_if.sv
// Memory-layer read port used by gam_winner_search: node address/enables out, node data back.
// The memory side answers combinationally within the same cycle.
interface gam_winner_search_if #(
  parameter int unsigned DIM    = 4,
  parameter int unsigned ELEM_W = 16
);
  logic [31:0]           mem_class_o;
  logic [31:0]           mem_node_o;
  logic                  mem_rd_wr_o;
  logic                  mem_W_c_o;
  logic                  mem_T_c_o;
  logic [DIM*ELEM_W-1:0] mem_W_i;
  logic [31:0]           mem_Th_i;

  modport master (
    output mem_class_o,
    output mem_node_o,
    output mem_rd_wr_o,
    output mem_W_c_o,
    output mem_T_c_o,
    input  mem_W_i,
    input  mem_Th_i
  );

  modport slave (
    input  mem_class_o,
    input  mem_node_o,
    input  mem_rd_wr_o,
    input  mem_W_c_o,
    input  mem_T_c_o,
    output mem_W_i,
    output mem_Th_i
  );
endinterface

// File: rtl/gam_winner_search.sv
// Sequential first/second nearest-node search over one class of the GAM memory layer.
// Optional GAM_WINNER_NOVELTY_EN builds the registered win1_dist > win1_th novelty flag.
module gam_winner_search #(
  parameter int unsigned DIM      = 4,
  parameter int unsigned ELEM_W   = 16,
  parameter int unsigned NODE_MAX = 16,
  parameter int unsigned DIST_W   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           class_i,
  input  logic [31:0]           node_count,
  input  logic [DIM*ELEM_W-1:0] X_i,
  gam_winner_search_if.master   mem,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           win1_node,
  output logic [DIST_W-1:0]     win1_dist,
  output logic [31:0]           win1_th,
  output logic [31:0]           win2_node,
  output logic [DIST_W-1:0]     win2_dist,
  output logic                  win2_valid,
  output logic                  err_empty,
  output logic                  novel
);

  localparam int unsigned CntW = $clog2(NODE_MAX + 1);
  localparam int unsigned KW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned SqW  = 2 * ELEM_W + 2;
  localparam int unsigned SumW = ((DIST_W > SqW) ? DIST_W : SqW) + 1;
  localparam logic [DIST_W-1:0] DistMax = '1;
  // RD_WR_T encoding: READ is 0.
  localparam logic RdWrRead = 1'b0;

  typedef enum logic [2:0] {StIdle, StFetch, StAcc, StCmp, StFin} state_e;

  state_e state_q, state_d;

  logic [31:0]           class_q, class_d;
  logic [CntW-1:0]       cnt_q, cnt_d, n_q, n_d, cnt_clamp;
  logic [CntW-1:0]       w1n_q, w1n_d, w2n_q, w2n_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DIM*ELEM_W-1:0] x_q, x_d, w_q, w_d;
  logic [31:0]           th_q, th_d, w1t_q, w1t_d;
  logic [DIST_W-1:0]     acc_q, acc_d, w1d_q, w1d_d, w2d_q, w2d_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  w2v_q, w2v_d, err_q, err_d;
  logic                  accept;

  logic signed [ELEM_W-1:0] x_el, w_el;
  logic signed [ELEM_W:0]   diff;
  logic signed [SqW-1:0]    diff_ext, sq_s;
  logic [SumW-1:0]          sum;
  logic [DIST_W-1:0]        acc_sat;

  assign accept = (state_q == StIdle) && start;

  // Negative or zero counts mean an empty class; large counts clamp to the table size.
  always_comb begin
    cnt_clamp = '0;
    if (!node_count[31] && (node_count != '0)) begin
      if (node_count > 32'(NODE_MAX)) begin
        cnt_clamp = CntW'(NODE_MAX);
      end else begin
        cnt_clamp = node_count[CntW-1:0];
      end
    end
  end

  // One element per ACC cycle; the square of a widened difference is never negative.
  assign x_el     = x_q[int'(k_q) * ELEM_W +: ELEM_W];
  assign w_el     = w_q[int'(k_q) * ELEM_W +: ELEM_W];
  assign diff     = {x_el[ELEM_W-1], x_el} - {w_el[ELEM_W-1], w_el};
  assign diff_ext = SqW'(diff);
  assign sq_s     = diff_ext * diff_ext;
  assign sum      = SumW'(acc_q) + SumW'(unsigned'(sq_s));
  assign acc_sat  = (sum > SumW'(DistMax)) ? DistMax : sum[DIST_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (cnt_clamp == '0) ? StFin : StFetch;
      StFetch: state_d = StAcc;
      StAcc:   if (k_q == KW'(DIM - 1)) state_d = StCmp;
      StCmp:   state_d = ((n_q + CntW'(1)) < cnt_q) ? StFetch : StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    class_d = class_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    k_d     = k_q;
    x_d     = x_q;
    w_d     = w_q;
    th_d    = th_q;
    acc_d   = acc_q;
    w1n_d   = w1n_q;
    w1d_d   = w1d_q;
    w1t_d   = w1t_q;
    w2n_d   = w2n_q;
    w2d_d   = w2d_q;
    w2v_d   = w2v_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = (state_q == StFin);
    case (state_q)
      StIdle: begin
        if (start) begin
          class_d = class_i;
          x_d     = X_i;
          cnt_d   = cnt_clamp;
          n_d     = '0;
          busy_d  = 1'b1;
          w1n_d   = '0;
          w1d_d   = DistMax;
          w1t_d   = '0;
          w2n_d   = '0;
          w2d_d   = DistMax;
          w2v_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        w_d   = mem.mem_W_i;
        th_d  = mem.mem_Th_i;
        acc_d = '0;
        k_d   = '0;
      end
      StAcc: begin
        acc_d = acc_sat;
        k_d   = k_q + KW'(1);
      end
      StCmp: begin
        // Strict compares: on a tie the earlier (lower index) node keeps its place.
        if (acc_q < w1d_q) begin
          w2n_d = w1n_q;
          w2d_d = w1d_q;
          w1n_d = n_q;
          w1d_d = acc_q;
          w1t_d = th_q;
        end else if (acc_q < w2d_q) begin
          w2n_d = n_q;
          w2d_d = acc_q;
        end
        n_d = n_q + CntW'(1);
      end
      StFin: begin
        busy_d = 1'b0;
        err_d  = (cnt_q == '0);
        w2v_d  = (cnt_q >= CntW'(2));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      class_q <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      th_q    <= '0;
      acc_q   <= '0;
      w1n_q   <= '0;
      w1d_q   <= DistMax;
      w1t_q   <= '0;
      w2n_q   <= '0;
      w2d_q   <= DistMax;
      w2v_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      k_q     <= k_d;
      x_q     <= x_d;
      w_q     <= w_d;
      th_q    <= th_d;
      acc_q   <= acc_d;
      w1n_q   <= w1n_d;
      w1d_q   <= w1d_d;
      w1t_q   <= w1t_d;
      w2n_q   <= w2n_d;
      w2d_q   <= w2d_d;
      w2v_q   <= w2v_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef GAM_WINNER_NOVELTY_EN
  localparam int unsigned CmpW = (DIST_W > 32) ? DIST_W : 32;

  logic        novel_q, novel_d;
  logic [31:0] th_pos;

  // A negative threshold counts as zero.
  assign th_pos = w1t_q[31] ? 32'd0 : w1t_q;

  always_comb begin
    novel_d = novel_q;
    if (accept) begin
      novel_d = 1'b0;
    end else if (state_q == StFin) begin
      novel_d = (cnt_q != '0) && (CmpW'(w1d_q) > CmpW'(th_pos));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      novel_q <= 1'b0;
    end else begin
      novel_q <= novel_d;
    end
  end

  assign novel = novel_q;
`else
  assign novel = 1'b0;
`endif

  assign mem.mem_class_o = class_q;
  assign mem.mem_node_o  = 32'(n_q);
  assign mem.mem_rd_wr_o = RdWrRead;
  assign mem.mem_W_c_o   = (state_q == StFetch);
  assign mem.mem_T_c_o   = (state_q == StFetch);

  assign busy       = busy_q;
  assign done       = done_q;
  assign win1_node  = 32'(w1n_q);
  assign win1_dist  = w1d_q;
  assign win1_th    = w1t_q;
  assign win2_node  = 32'(w2n_q);
  assign win2_dist  = w2d_q;
  assign win2_valid = w2v_q;
  assign err_empty  = err_q;

endmodule
